// File: rtl/paddle_controller_if.sv
// rtl/paddle_controller_if.sv - paddle controller signal bundle
// Purpose: groups the board/ball/paddle inputs and the move/state outputs of one
//          paddle controller.
// Signals:
//   btnUp, btnDown  raw pushbuttons (asynchronous, active-high)
//   cpuMode         1 = CPU player drives the paddle
//   pause           1 = freeze paddle motion
//   ballY           ball top y
//   paddleTop       paddle top y
//   paddleMove      bit0 = up, bit1 = down (one-cycle pulse per move tick)
//   state           0 PAUSED, 1 HUMAN, 2 CPU_WAIT, 3 CPU_TRACK
// Modports: master drives the inputs (board/testbench), slave is the controller.
interface paddle_controller_if;
  logic       btnUp;
  logic       btnDown;
  logic       cpuMode;
  logic       pause;
  logic [9:0] ballY;
  logic [9:0] paddleTop;
  logic [1:0] paddleMove;
  logic [1:0] state;

  modport master (
    output btnUp, btnDown, cpuMode, pause, ballY, paddleTop,
    input  paddleMove, state
  );

  modport slave (
    input  btnUp, btnDown, cpuMode, pause, ballY, paddleTop,
    output paddleMove, state
  );
endinterface

// File: rtl/paddle_controller.sv
// rtl/paddle_controller.sv - paddle move command generator (buttons or CPU player)
// Purpose: debounces the paddle buttons, divides PixelClock into move ticks and,
//          once per tick, emits a one-cycle up/down command chosen either by the
//          buttons (HUMAN) or by tracking the ball (CPU_TRACK), with screen-edge guard.
// Ports:
//   PixelClock  system clock
//   Reset       synchronous, active-high
//   bus         paddle_controller_if.slave (buttons, mode, pause, ballY, paddleTop
//               in; paddleMove, state out)
module paddle_controller #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int STEP_DIV        = 100000,
  parameter int PADDLE_HEIGHT   = 150,
  parameter int SCREEN_HEIGHT   = 600,
  parameter int DEAD_ZONE       = 8,
  parameter int REACT_TICKS     = 3
) (
  input logic                PixelClock,
  input logic                Reset,
  paddle_controller_if.slave bus
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DIV_W = $clog2(STEP_DIV);
  localparam int RW    = (REACT_TICKS < 1) ? 1 : $clog2(REACT_TICKS + 1);
  localparam logic signed [11:0] DZ = 12'(DEAD_ZONE);

  typedef enum logic [1:0] {
    PAUSED    = 2'd0,
    HUMAN     = 2'd1,
    CPU_WAIT  = 2'd2,
    CPU_TRACK = 2'd3
  } state_e;

  logic [1:0]       up_sync_q, up_sync_d, dn_sync_q, dn_sync_d;
  logic             up_deb_q, up_deb_d, dn_deb_q, dn_deb_d;
  logic [DB_W-1:0]  up_cnt_q, up_cnt_d, dn_cnt_q, dn_cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [RW-1:0]    react_q, react_d;
  state_e           state_q, state_d;
  logic [1:0]       move_q, move_d;

  logic              tick;
  logic [10:0]       centre;
  logic [10:0]       bottom;
  logic signed [11:0] diff;
  logic [1:0]        decision;
  logic [1:0]        guarded;

  // Returns {next debounced level, next counter}. The level flips only after
  // DEBOUNCE_CYCLES consecutive samples that disagree with it.
  function automatic logic [DB_W:0] db_step(input logic sync, input logic deb,
                                            input logic [DB_W-1:0] cnt);
    if (sync == deb) return {deb, DB_W'(0)};
    if (cnt == DB_W'(DEBOUNCE_CYCLES - 1)) return {sync, DB_W'(0)};
    return {deb, cnt + DB_W'(1)};
  endfunction

  always_comb begin
    up_sync_d = {up_sync_q[0], bus.btnUp};
    dn_sync_d = {dn_sync_q[0], bus.btnDown};
    {up_deb_d, up_cnt_d} = db_step(up_sync_q[1], up_deb_q, up_cnt_q);
    {dn_deb_d, dn_cnt_d} = db_step(dn_sync_q[1], dn_deb_q, dn_cnt_q);

    tick = (div_q == DIV_W'(STEP_DIV - 1));

    state_d = state_q;
    react_d = react_q;
    if (bus.pause) begin
      state_d = PAUSED;
    end else begin
      case (state_q)
        PAUSED, HUMAN: begin
          if (bus.cpuMode) begin
            state_d = CPU_WAIT;
            react_d = RW'(REACT_TICKS);
          end else begin
            state_d = HUMAN;
          end
        end
        CPU_WAIT: begin
          // react is tested before it is decremented, so REACT_TICKS=0 tracks at once
          if (!bus.cpuMode)             state_d = HUMAN;
          else if (react_q == RW'(0))   state_d = CPU_TRACK;
          else if (tick)                react_d = react_q - RW'(1);
        end
        default: begin
          if (!bus.cpuMode) state_d = HUMAN;
        end
      endcase
    end

    // Cleared on the way into PAUSED and held through the first non-paused cycle,
    // so the first tick after a pause lands a full STEP_DIV cycles later.
    if (state_q == PAUSED || state_d == PAUSED) div_d = '0;
    else if (tick)                              div_d = '0;
    else                                        div_d = div_q + DIV_W'(1);

    centre = {1'b0, bus.paddleTop} + 11'(PADDLE_HEIGHT / 2);
    bottom = {1'b0, bus.paddleTop} + 11'(PADDLE_HEIGHT);
    diff   = $signed({2'b00, bus.ballY}) - $signed({1'b0, centre});

    decision = 2'b00;
    case (state_q)
      HUMAN: begin
        case ({dn_deb_q, up_deb_q})
          2'b01:   decision = 2'b01;
          2'b10:   decision = 2'b10;
          default: decision = 2'b00;
        endcase
      end
      CPU_TRACK: begin
        if (diff > DZ)       decision = 2'b10;
        else if (diff < -DZ) decision = 2'b01;
      end
      default: decision = 2'b00;
    endcase

    guarded = decision;
    if (bus.paddleTop <= 10'd1)              guarded[0] = 1'b0;
    if (bottom >= 11'(SCREEN_HEIGHT - 1))    guarded[1] = 1'b0;

    move_d = tick ? guarded : 2'b00;
  end

  always_ff @(posedge PixelClock) begin
    if (Reset) begin
      up_sync_q <= '0;
      dn_sync_q <= '0;
      up_deb_q  <= 1'b0;
      dn_deb_q  <= 1'b0;
      up_cnt_q  <= '0;
      dn_cnt_q  <= '0;
      div_q     <= '0;
      react_q   <= '0;
      state_q   <= PAUSED;
      move_q    <= 2'b00;
    end else begin
      up_sync_q <= up_sync_d;
      dn_sync_q <= dn_sync_d;
      up_deb_q  <= up_deb_d;
      dn_deb_q  <= dn_deb_d;
      up_cnt_q  <= up_cnt_d;
      dn_cnt_q  <= dn_cnt_d;
      div_q     <= div_d;
      react_q   <= react_d;
      state_q   <= state_d;
      move_q    <= move_d;
    end
  end

  assign bus.paddleMove = move_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_paddle_controller.sv
// tb/tb_paddle_controller.sv - directed self-checking bench for paddle_controller
module tb_paddle_controller;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  paddle_controller_if bus();

  paddle_controller #(
    .DEBOUNCE_CYCLES(4),
    .STEP_DIV       (8),
    .PADDLE_HEIGHT  (150),
    .SCREEN_HEIGHT  (600),
    .DEAD_ZONE      (8),
    .REACT_TICKS    (2)
  ) dut (
    .PixelClock(clk),
    .Reset     (rst),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, passed=%0d total=%0d", pass_cnt, total_cnt);
    $fatal(1);
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_pulse(input int max, output int n, output logic [1:0] v);
    n = 0;
    v = 2'b00;
    while (n < max) begin
      step(1);
      n++;
      if (bus.paddleMove != 2'b00) begin
        v = bus.paddleMove;
        return;
      end
    end
  endtask

  task automatic wait_state(input logic [1:0] target, input int max, output int n);
    n = 0;
    while (n < max && bus.state != target) begin
      step(1);
      n++;
    end
  endtask

  task automatic count_moves(input int cycles, input logic [1:0] allowed,
                             output int nonzero, output int other);
    nonzero = 0;
    other   = 0;
    for (int i = 0; i < cycles; i++) begin
      step(1);
      if (bus.paddleMove != 2'b00) nonzero++;
      if (bus.paddleMove != 2'b00 && bus.paddleMove != allowed) other++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.pause = 1'b0;
    bus.cpuMode = 1'b0;
    bus.btnUp = 1'b1;
    bus.btnDown = 1'b0;
    bus.paddleTop = 10'd300;
    bus.ballY = 10'd0;
    step(3);
    total_cnt++;
    if (bus.paddleMove !== 2'b00) $display("FAIL reset_move: got %b expected 00", bus.paddleMove);
    else pass_cnt++;
    total_cnt++;
    if (bus.state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", bus.state);
    else pass_cnt++;
    rst = 1'b0;
    step(1);
    total_cnt++;
    if (bus.state !== 2'd1) $display("FAIL human_entry: got state %0d expected 1", bus.state);
    else pass_cnt++;
  endtask

  task automatic test_human_up();
    int n;
    logic [1:0] v;
    wait_pulse(40, n, v);
    total_cnt++;
    if (v !== 2'b01) $display("FAIL human_first_pulse: got %b expected 01", v);
    else pass_cnt++;
    for (int k = 0; k < 2; k++) begin
      wait_pulse(20, n, v);
      total_cnt++;
      if (v !== 2'b01 || n != 8) $display("FAIL human_period: got move %b after %0d cycles expected 01 after 8", v, n);
      else pass_cnt++;
    end
  endtask

  task automatic test_glitch();
    int nz;
    int bad;
    nz = 0;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      bus.btnDown = (i < 3);
      step(1);
      if (bus.paddleMove != 2'b00) nz++;
      if (bus.paddleMove != 2'b00 && bus.paddleMove != 2'b01) bad++;
    end
    total_cnt++;
    if (nz != 2 || bad != 0) $display("FAIL down_glitch: got %0d pulses (%0d not 01) expected 2 (0)", nz, bad);
    else pass_cnt++;
    bus.btnDown = 1'b1;
    step(10);
    count_moves(16, 2'b00, nz, bad);
    total_cnt++;
    if (nz != 0) $display("FAIL both_buttons: got %0d pulses expected 0", nz);
    else pass_cnt++;
    bus.btnDown = 1'b0;
    step(10);
  endtask

  task automatic test_cpu();
    int n;
    logic [1:0] v;
    int nz;
    int bad;
    wait_pulse(20, n, v);
    total_cnt++;
    if (v !== 2'b01) $display("FAIL cpu_align: got %b expected 01", v);
    else pass_cnt++;
    bus.cpuMode = 1'b1;
    bus.paddleTop = 10'd100;
    bus.ballY = 10'd300;
    step(1);
    total_cnt++;
    if (bus.state !== 2'd2) $display("FAIL cpu_wait_entry: got state %0d expected 2", bus.state);
    else pass_cnt++;
    step(15);
    total_cnt++;
    if (bus.state !== 2'd2) $display("FAIL cpu_wait_hold: got state %0d expected 2", bus.state);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if (bus.state !== 2'd3) $display("FAIL cpu_track_entry: got state %0d expected 3", bus.state);
    else pass_cnt++;
    wait_pulse(20, n, v);
    total_cnt++;
    if (v !== 2'b10 || n != 7) $display("FAIL cpu_down_first: got move %b after %0d cycles expected 10 after 7", v, n);
    else pass_cnt++;
    wait_pulse(20, n, v);
    total_cnt++;
    if (v !== 2'b10 || n != 8) $display("FAIL cpu_down_next: got move %b after %0d cycles expected 10 after 8", v, n);
    else pass_cnt++;
    bus.ballY = 10'd180;
    count_moves(8, 2'b00, nz, bad);
    total_cnt++;
    if (nz != 0) $display("FAIL cpu_dead_zone: got %0d pulses expected 0", nz);
    else pass_cnt++;
    bus.ballY = 10'd160;
    wait_pulse(20, n, v);
    total_cnt++;
    if (v !== 2'b01 || n != 8) $display("FAIL cpu_up: got move %b after %0d cycles expected 01 after 8", v, n);
    else pass_cnt++;
  endtask

  task automatic test_edge_guard();
    int n;
    logic [1:0] v;
    int nz;
    int bad;
    bus.cpuMode = 1'b0;
    bus.paddleTop = 10'd1;
    step(1);
    total_cnt++;
    if (bus.state !== 2'd1) $display("FAIL guard_human: got state %0d expected 1", bus.state);
    else pass_cnt++;
    count_moves(16, 2'b00, nz, bad);
    total_cnt++;
    if (nz != 0) $display("FAIL guard_top: got %0d pulses expected 0", nz);
    else pass_cnt++;
    bus.paddleTop = 10'd2;
    wait_pulse(20, n, v);
    total_cnt++;
    if (v !== 2'b01) $display("FAIL guard_top_clear: got %b expected 01", v);
    else pass_cnt++;
    bus.btnUp = 1'b0;
    bus.btnDown = 1'b1;
    bus.paddleTop = 10'd449;
    step(10);
    count_moves(16, 2'b00, nz, bad);
    total_cnt++;
    if (nz != 0) $display("FAIL guard_bottom: got %0d pulses expected 0", nz);
    else pass_cnt++;
    bus.paddleTop = 10'd448;
    wait_pulse(20, n, v);
    total_cnt++;
    if (v !== 2'b10) $display("FAIL guard_bottom_clear: got %b expected 10", v);
    else pass_cnt++;
  endtask

  task automatic test_pause();
    int n;
    logic [1:0] v;
    int nz;
    int bad;
    bus.btnDown = 1'b0;
    bus.cpuMode = 1'b1;
    bus.paddleTop = 10'd100;
    bus.ballY = 10'd300;
    wait_state(2'd3, 40, n);
    total_cnt++;
    if (bus.state !== 2'd3) $display("FAIL pause_setup: got state %0d expected 3", bus.state);
    else pass_cnt++;
    wait_pulse(20, n, v);
    total_cnt++;
    if (v !== 2'b10) $display("FAIL pause_setup_pulse: got %b expected 10", v);
    else pass_cnt++;
    step(3);
    bus.pause = 1'b1;
    step(1);
    total_cnt++;
    if (bus.state !== 2'd0) $display("FAIL pause_enter: got state %0d expected 0", bus.state);
    else pass_cnt++;
    count_moves(16, 2'b00, nz, bad);
    total_cnt++;
    if (nz != 0 || bus.state !== 2'd0) $display("FAIL pause_hold: got %0d pulses state %0d expected 0 pulses state 0", nz, bus.state);
    else pass_cnt++;
    bus.pause = 1'b0;
    step(1);
    total_cnt++;
    if (bus.state !== 2'd2) $display("FAIL unpause: got state %0d expected 2", bus.state);
    else pass_cnt++;
    step(16);
    total_cnt++;
    if (bus.state !== 2'd2) $display("FAIL unpause_wait: got state %0d expected 2", bus.state);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if (bus.state !== 2'd3) $display("FAIL unpause_track: got state %0d expected 3", bus.state);
    else pass_cnt++;
    wait_pulse(20, n, v);
    total_cnt++;
    if (v !== 2'b10 || n != 7) $display("FAIL unpause_pulse: got move %b after %0d cycles expected 10 after 7", v, n);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    rst = 1'b1;
    step(1);
    total_cnt++;
    if (bus.paddleMove !== 2'b00) $display("FAIL reset_mid_pulse_move: got %b expected 00", bus.paddleMove);
    else pass_cnt++;
    total_cnt++;
    if (bus.state !== 2'd0) $display("FAIL reset_mid_pulse_state: got %0d expected 0", bus.state);
    else pass_cnt++;
    rst = 1'b0;
    bus.cpuMode = 1'b0;
    step(1);
    total_cnt++;
    if (bus.state !== 2'd1) $display("FAIL toggle_human: got state %0d expected 1", bus.state);
    else pass_cnt++;
    bus.cpuMode = 1'b1;
    step(1);
    total_cnt++;
    if (bus.state !== 2'd2) $display("FAIL toggle_cpu: got state %0d expected 2", bus.state);
    else pass_cnt++;
    bus.cpuMode = 1'b0;
    step(1);
    total_cnt++;
    if (bus.state !== 2'd1) $display("FAIL toggle_back: got state %0d expected 1", bus.state);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    rst = 1'b1;
    bus.btnUp = 1'b0;
    bus.btnDown = 1'b0;
    bus.cpuMode = 1'b0;
    bus.pause = 1'b0;
    bus.ballY = 10'd0;
    bus.paddleTop = 10'd300;
    test_reset();
    test_human_up();
    test_glitch();
    test_cpu();
    test_edge_guard();
    test_pause();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
